uart_rx_buf: RTL and testbench

UART_RX_BUF -- requirements
Module: uart_rx_buf

---
 rtl/uart_rx_buf.sv | 148 ++++++++++++++
 tb/tb_uart_rx_buf.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buf.sv
//==============================================================================
// Module      : uart_rx_buf
// Description : Polled console receive buffer. Periodically asks the simulation
//               harness for a character and stores valid replies in a small
//               first-word fall-through FIFO read by the LSU MMIO path.
//               Optional macro UART_RX_CRLF_EN: store carriage return (8'h0D)
//               as line feed (8'h0A).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_buf #(
  parameter int DEPTH    = 4,   // FIFO entries, power of two in 2..16
  parameter int POLL_GAP = 16   // idle cycles between console polls, 1..255
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       io_uart_in_valid,
  input  logic [7:0]                 io_uart_in_ch,
  output logic                       o_rx_valid,
  output logic [7:0]                 o_rx_ch,
  input  logic                       i_rx_ready,
  input  logic                       i_rx_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_rx_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [7:0]    C_GAP_MAX = 8'(POLL_GAP - 1);
  localparam logic [7:0]    C_NO_CHAR = 8'hFF;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    gap_q, gap_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic          push_en;
  logic          pop_en;
  logic [7:0]    push_data;

  // A reply is only meaningful in the single REQ cycle; 8'hFF means "nothing".
  assign push_en = (state_q == S_REQ) && (io_uart_in_ch != C_NO_CHAR);
  assign pop_en  = (count_q != '0) && i_rx_ready;

`ifdef UART_RX_CRLF_EN
  // Normalise carriage return to line feed on the way into the FIFO.
  assign push_data = (io_uart_in_ch == 8'h0D) ? 8'h0A : io_uart_in_ch;
`else
  assign push_data = io_uart_in_ch;
`endif

  // Poll scheduler: count idle cycles, request once the gap has elapsed and
  // there is room for the reply, then return to idle after one cycle.
  always_comb begin
    state_d          = state_q;
    gap_d            = gap_q;
    io_uart_in_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gap_q == C_GAP_MAX) begin
          if (count_q < C_DEPTH) begin
            state_d = S_REQ;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_REQ: begin
        io_uart_in_valid = 1'b1;
        state_d          = S_IDLE;
        gap_d            = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        gap_d   = 8'd0;
      end
    endcase
    // Flush abandons any poll in progress and restarts the gap.
    if (i_rx_flush) begin
      state_d = S_IDLE;
      gap_d   = 8'd0;
    end
  end

  // FIFO bookkeeping: separate count keeps full and empty distinguishable
  // while the pointers simply wrap modulo DEPTH.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (i_rx_flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + PW'(1);
      end
      if (pop_en) begin
        rd_d = rd_q + PW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register; reset outranks flush, push and pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      gap_q   <= 8'd0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign o_rx_valid = (count_q != '0);
  assign o_rx_ch    = o_rx_valid ? mem_q[rd_q] : 8'h00;
  assign o_rx_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buf.sv
//==============================================================================
// Module      : tb_uart_rx_buf
// Description : Randomised self-checking bench for uart_rx_buf against a
//               queue-based reference model (elapsed-time poll schedule).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rx_buf;

  localparam int DEPTH    = 4;
  localparam int POLL_GAP = 16;
  localparam int CW       = $clog2(DEPTH+1);

  logic          clock;
  logic          reset;
  logic          io_uart_in_valid;
  logic [7:0]    io_uart_in_ch;
  logic          o_rx_valid;
  logic [7:0]    o_rx_ch;
  logic          i_rx_ready;
  logic          i_rx_flush;
  logic [CW-1:0] o_rx_count;

  uart_rx_buf #(
    .DEPTH    (DEPTH),
    .POLL_GAP (POLL_GAP)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .io_uart_in_valid (io_uart_in_valid),
    .io_uart_in_ch    (io_uart_in_ch),
    .o_rx_valid       (o_rx_valid),
    .o_rx_ch          (o_rx_ch),
    .i_rx_ready       (i_rx_ready),
    .i_rx_flush       (i_rx_flush),
    .o_rx_count       (o_rx_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: characters waiting for the consumer, in arrival order,
  // plus the number of idle cycles since the last poll/reset/flush.
  logic [7:0] model_q[$];
  int         elapsed  = 0;
  bit         poll_now = 1'b0;
  int         cyc      = 0;        // cycles since last reset release
  int         first_poll = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] stored(input logic [7:0] c);
`ifdef UART_RX_CRLF_EN
    return (c == 8'h0D) ? 8'h0A : c;
`else
    return c;
`endif
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit rst, input bit rdy, input bit fl, input logic [7:0] ch);
    int  sz;
    bit  nxt;
    @(negedge clock);
    reset         = rst;
    i_rx_ready    = rdy;
    i_rx_flush    = fl;
    io_uart_in_ch = ch;
    #1;
    sz = model_q.size();
    check("poll",  {31'd0, io_uart_in_valid}, {31'd0, poll_now});
    check("count", {{(32-CW){1'b0}}, o_rx_count}, sz);
    check("valid", {31'd0, o_rx_valid}, {31'd0, (sz != 0)});
    check("head",  {24'd0, o_rx_ch}, {24'd0, (sz != 0) ? model_q[0] : 8'h00});
    if (poll_now && first_poll < 0) first_poll = cyc;
    @(posedge clock);
    if (rst) begin
      model_q.delete();
      elapsed    = 0;
      poll_now   = 1'b0;
      cyc        = 0;
      first_poll = -1;
    end else begin
      cyc++;
      if (fl) begin
        model_q.delete();
        elapsed  = 0;
        poll_now = 1'b0;
      end else begin
        if (rdy && sz != 0) void'(model_q.pop_front());
        if (poll_now) begin
          if (ch != 8'hFF) model_q.push_back(stored(ch));
          elapsed  = 0;
          poll_now = 1'b0;
        end else begin
          nxt      = (elapsed >= POLL_GAP - 1) && (sz < DEPTH);
          elapsed++;
          poll_now = nxt;
        end
      end
    end
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 99);
    if (r < 30)      return 8'hFF;
    else if (r < 40) return 8'h0D;
    else             return 8'($urandom_range(0, 254));
  endfunction

  initial begin
    logic [7:0] seq [5];
    logic [7:0] digit;
    int         idx;
    int         rdy_pct;
    bit         r, f, rd;

    seq[0] = "A"; seq[1] = "B"; seq[2] = "C"; seq[3] = "D"; seq[4] = "E";
    reset = 1'b1; i_rx_ready = 1'b0; i_rx_flush = 1'b0; io_uart_in_ch = 8'hFF;

    // Reset, then an empty console: regular polls, nothing stored.
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'hFF);
    repeat (60) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'hFF);
    check("first_poll", first_poll, POLL_GAP);

    // Five characters with no consumer: fills, stalls, then drains in order.
    idx = 0;
    for (int i = 0; i < 120; i++) begin
      step(1'b0, 1'b0, 1'b0, (idx < 5) ? seq[idx] : 8'hFF);
      if (dut.io_uart_in_valid === 1'b1 && idx < 5) idx++;
    end
    check("full_count", {{(32-CW){1'b0}}, o_rx_count}, DEPTH);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b1, 1'b0, (idx < 5) ? seq[idx] : 8'hFF);
      if (dut.io_uart_in_valid === 1'b1 && idx < 5) idx++;
    end

    // Pointer wrap: digits one at a time, consumed as they arrive.
    idx = 0;
    for (int i = 0; i < 200; i++) begin
      digit = 8'h30 + 8'(idx);
      step(1'b0, 1'b1, 1'b0, (idx < 10) ? digit : 8'hFF);
      if (dut.io_uart_in_valid === 1'b1 && idx < 10) idx++;
      if (o_rx_count > 1) check("wrap_count", {{(32-CW){1'b0}}, o_rx_count}, 1);
    end

    // Random traffic: varying consumer pressure, flushes and resets, with
    // extra weight on hitting the poll cycle itself.
    for (int seg = 0; seg < 12; seg++) begin
      rdy_pct = $urandom_range(0, 100);
      for (int i = 0; i < 250; i++) begin
        rd = ($urandom_range(0, 99) < rdy_pct);
        f  = poll_now ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
        r  = poll_now ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 499) == 0);
        step(r, rd, f, rand_char());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
